// File: rtl/sparse_expand_if.sv
// Sparse-beat input channel and dense-frame output channel for sparse_expand.
// slave is the expander's view; master is the producer/consumer side.
interface sparse_expand_if #(
    parameter int N    = 8,
    parameter int LOGN = 3,
    parameter int W    = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [LOGN-1:0]   in_addr;
    logic [W-1:0]      in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_mask;
    logic [N*W-1:0]    out_data;
    logic [LOGN:0]     out_count;
    logic              dup_err;

    modport slave (
        input  in_valid, in_addr, in_data, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_data, out_count, dup_err
    );

    modport master (
        output in_valid, in_addr, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_data, out_count, dup_err
    );
endinterface

// File: rtl/sparse_expand.sv
// Collects (index, value) beats into a dense N-element frame and holds it
// until the consumer takes it.
//
// state   | meaning
// COLLECT | accepting beats, building mask/count/dup for the current frame
// HOLD    | frame complete, presented on out_* until out_ready
module sparse_expand #(
    parameter int N    = 8,
    parameter int LOGN = 3,
    parameter int W    = 8
) (
    input logic            clk,
    input logic            rst_n,
    sparse_expand_if.slave bus
);
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state_q;
    logic            out_valid_q;
    logic [N-1:0]    mask_q;
    logic [LOGN:0]   count_q;
    logic            dup_q;
    logic [W-1:0]    slot_q [N];
    logic            accept;

    // Held low through reset so nothing is taken while the frame is discarded.
    assign bus.in_ready  = rst_n & (state_q == COLLECT);
    assign accept        = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
            mask_q      <= '0;
            count_q     <= '0;
            dup_q       <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        mask_q[bus.in_addr] <= 1'b1;
                        if (mask_q[bus.in_addr]) begin
                            dup_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                        if (bus.in_last) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= COLLECT;
                        out_valid_q <= 1'b0;
                        mask_q      <= '0;
                        count_q     <= '0;
                        dup_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Slot storage is left unreset; the mask gates stale contents on output.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[bus.in_addr] <= bus.in_data;
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (mask_q[i]) begin
                bus.out_data[i*W +: W] = slot_q[i];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_mask  = mask_q;
    assign bus.out_count = count_q;
    assign bus.dup_err   = dup_q;
endmodule

// File: tb/tb_sparse_expand.sv
// Directed bench for sparse_expand: hand-computed frames, backpressure,
// handshake bubble and mid-frame reset.
module tb_sparse_expand;
    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int W    = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    sparse_expand_if #(.N(N), .LOGN(LOGN), .W(W)) bus ();

    sparse_expand #(.N(N), .LOGN(LOGN), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [LOGN-1:0] a, input logic [W-1:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mask",      64'(bus.out_mask),  64'd0);
        chk("rst_count",     64'(bus.out_count), 64'd0);
        chk("rst_dup",       64'(bus.dup_err),   64'd0);
        chk("rst_data",      64'(bus.out_data),  64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Two distinct indices
        send_beat(3'd1, 8'h11, 1'b0);
        chk("f1_partial_count", 64'(bus.out_count), 64'd1);
        chk("f1_partial_valid", 64'(bus.out_valid), 64'd0);
        send_beat(3'd4, 8'h44, 1'b1);
        chk("f1_valid",    64'(bus.out_valid), 64'd1);
        chk("f1_in_ready", 64'(bus.in_ready),  64'd0);
        chk("f1_mask",     64'(bus.out_mask),  64'h12);
        chk("f1_data",     64'(bus.out_data),  64'h0000_0044_0000_1100);
        chk("f1_count",    64'(bus.out_count), 64'd2);
        chk("f1_dup",      64'(bus.dup_err),   64'd0);
        handshake();
        chk("f1_hs_valid",    64'(bus.out_valid), 64'd0);
        chk("f1_hs_in_ready", 64'(bus.in_ready),  64'd1);
        chk("f1_hs_mask",     64'(bus.out_mask),  64'd0);
        chk("f1_hs_data",     64'(bus.out_data),  64'd0);

        // Duplicate index overwrites
        send_beat(3'd3, 8'hAA, 1'b0);
        send_beat(3'd3, 8'hBB, 1'b1);
        chk("f2_mask",  64'(bus.out_mask),  64'h08);
        chk("f2_data",  64'(bus.out_data),  64'h0000_0000_BB00_0000);
        chk("f2_count", 64'(bus.out_count), 64'd1);
        chk("f2_dup",   64'(bus.dup_err),   64'd1);
        handshake();
        chk("f2_hs_dup", 64'(bus.dup_err), 64'd0);

        // Full frame, descending indices
        for (int i = 7; i >= 0; i--) begin
            send_beat(3'(i), 8'(i * 17), (i == 0));
        end
        chk("f3_valid", 64'(bus.out_valid), 64'd1);
        chk("f3_mask",  64'(bus.out_mask),  64'hFF);
        chk("f3_data",  64'(bus.out_data),  64'h7766_5544_3322_1100);
        chk("f3_count", 64'(bus.out_count), 64'd8);
        chk("f3_dup",   64'(bus.dup_err),   64'd0);

        // Backpressure in HOLD with a pending beat
        bus.in_valid = 1'b1;
        bus.in_addr  = 3'd0;
        bus.in_data  = 8'hEE;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid",    64'(bus.out_valid), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
            chk("bp_data",     64'(bus.out_data),  64'h7766_5544_3322_1100);
        end
        chk("bp_count", 64'(bus.out_count), 64'd8);

        // Handshake cycle with in_valid high: beat waits one cycle
        bus.in_addr   = 3'd2;
        bus.in_data   = 8'h22;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bub_valid",    64'(bus.out_valid), 64'd0);
        chk("bub_in_ready", 64'(bus.in_ready),  64'd1);
        chk("bub_mask",     64'(bus.out_mask),  64'd0);
        chk("bub_count",    64'(bus.out_count), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("f4_valid", 64'(bus.out_valid), 64'd1);
        chk("f4_mask",  64'(bus.out_mask),  64'h04);
        chk("f4_data",  64'(bus.out_data),  64'h0000_0000_0022_0000);
        chk("f4_count", 64'(bus.out_count), 64'd1);
        chk("f4_dup",   64'(bus.dup_err),   64'd0);
        handshake();

        // Mid-frame reset discards partial frame
        send_beat(3'd5, 8'h99, 1'b0);
        send_beat(3'd6, 8'h66, 1'b0);
        chk("pre_rst_count", 64'(bus.out_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    64'(bus.out_valid), 64'd0);
        chk("mid_rst_mask",     64'(bus.out_mask),  64'd0);
        chk("mid_rst_count",    64'(bus.out_count), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready),  64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst2_valid", 64'(bus.out_valid), 64'd0);
        send_beat(3'd5, 8'h55, 1'b1);
        chk("f5_valid", 64'(bus.out_valid), 64'd1);
        chk("f5_mask",  64'(bus.out_mask),  64'h20);
        chk("f5_data",  64'(bus.out_data),  64'h0000_5500_0000_0000);
        chk("f5_count", 64'(bus.out_count), 64'd1);
        chk("f5_dup",   64'(bus.dup_err),   64'd0);
        handshake();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sparse_expand.md
SPARSE_EXPAND -- requirements
Module: sparse_expand

Interface
REQ-001 SHALL have parameter N, default 8, meaning dense vector length (elements).
REQ-002 SHALL have parameter LOGN, default 3, meaning index width, log2(N).
REQ-003 SHALL have parameter W, default 8, meaning element data width.
REQ-004 SHALL have port clk  input  1  the single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  sparse beat valid.
REQ-007 SHALL have port in_ready  output  1  sparse beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_addr  input  LOGN  element index of beat.
REQ-009 SHALL have port in_data  input  W  element value of beat.
REQ-010 SHALL have port in_last  input  1  final beat of frame.
REQ-011 SHALL have port out_valid  output  1  dense frame available.
REQ-012 SHALL have port out_ready  input  1  consumer takes frame when out_valid && out_ready.
REQ-013 SHALL have port out_mask  output  N  occupancy; bit i set iff index i was written in the frame.
REQ-014 SHALL have port out_data  output  N*W  dense vector; element i at bits [i*W +: W].
REQ-015 SHALL have port out_count  output  LOGN+1  number of distinct indices written.
REQ-016 SHALL have port dup_err  output  1  at least one index written twice in the frame.

Function
REQ-017 SHALL implement two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 In COLLECT, each accepted beat SHALL, on that clock edge, set mask[in_addr] and store in_data into slot in_addr.
REQ-019 An accepted beat whose index bit is already set SHALL overwrite the slot, leave count unchanged, and set dup_err (sticky for the frame).
REQ-020 An accepted beat to a new index SHALL increment count by 1; count SHALL never exceed N.
REQ-021 An accepted beat with in_last=1 SHALL be applied like any beat and move state to HOLD; out_valid SHALL be 1 the following cycle (latency 1 cycle from last beat).
REQ-022 Every frame SHALL contain at least one beat; there is no empty-frame encoding.
REQ-023 out_data element i SHALL be zero whenever out_mask[i]=0, regardless of stale slot contents.
REQ-024 In HOLD, out_mask, out_data, out_count and dup_err SHALL stay stable until the handshake completes.
REQ-025 In HOLD, on out_valid && out_ready, the next state SHALL be COLLECT with mask, count and dup_err cleared on that edge.
REQ-026 in_valid during HOLD SHALL NOT be accepted, including in the handshake cycle; the first acceptance is the cycle after return to COLLECT (one-cycle bubble).
REQ-027 In COLLECT, out_mask/out_count/dup_err SHALL reflect the partial frame, but out_valid=0 makes them don't-care to consumers.
REQ-028 in_addr SHALL be fully decoded; all 2^LOGN values are legal when N=2^LOGN.

Reset
REQ-029 On rst_n=0, asynchronously: state=COLLECT, out_valid=0, mask=0, count=0, dup_err=0; out_data therefore reads all zero.
REQ-030 in_ready SHALL be 1 while rst_n=0 is not asserted and state is COLLECT; in_ready SHALL be 0 while rst_n=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; no frame is emitted for it.
REQ-032 Stored slot data need not be reset (masked by REQ-023).

Verification
REQ-033 Beats (1,0x11),(4,0x44,last) -> next cycle out_valid=1, out_mask=0x12, slot1=0x11, slot4=0x44, other slots 0, out_count=2, dup_err=0.
REQ-034 Beats (3,0xAA),(3,0xBB,last) -> out_mask=0x08, slot3=0xBB, out_count=1, dup_err=1.
REQ-035 Beats at indices 7,6,...,0 (last on 0) -> out_mask=0xFF, out_count=8, all slots match written values.
REQ-036 out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> out_valid stays 1, in_ready stays 0, outputs unchanged; after handshake, next accepted beat (2,0x22,last) yields out_mask=0x04, out_count=1, dup_err=0.
REQ-037 rst_n pulsed low after 2 beats of a frame -> out_valid=0, mask 0 immediately; after release, (5,0x55,last) yields out_mask=0x20, out_count=1, only slot5 nonzero.
REQ-038 Handshake cycle with in_valid=1 -> beat not accepted that cycle; accepted on the following cycle.
